// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// song_sequencer: walks the song stored in memory one 16-bit word at a time,
// separating tempo/end commands from note words and handing notes downstream.
module song_sequencer #(
  parameter int READ_WAIT   = 16,
  parameter int BPM_RESET   = 80,
  parameter int MAX_CMD_RUN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic [15:0] mem_data,
  input  logic        note_done,
  output logic        mem_next,
  output logic        mem_rewind,
  output logic        note_valid,
  output logic [1:0]  mode,
  output logic [3:0]  note,
  output logic [5:0]  tone,
  output logic [7:0]  default_bpm,
  output logic        end_song,
  output logic        fault
);

  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int RUN_W = $clog2(MAX_CMD_RUN + 1);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_CMD_RUN);
  localparam logic [7:0]       BPM_INIT  = 8'(BPM_RESET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DECODE,
    S_PLAYING,
    S_PAUSED,
    S_ADVANCE,
    S_END,
    S_STOPPED
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic [15:0]      word, word_d;
  logic [RUN_W-1:0] cmd_run, cmd_run_d;
  logic [RUN_W-1:0] run_inc;
  logic             armed, armed_d;
  logic [1:0]       mode_d;
  logic [3:0]       note_d;
  logic [5:0]       tone_d;
  logic [7:0]       bpm_d;
  logic             fault_d;

  logic is_cmd, is_end, is_rest, done_edge;

  // Word classification of the latched word.
  assign is_cmd  = (word[15:14] == 2'b11);
  assign is_end  = is_cmd && (word[7:0] == 8'h00);
  assign is_rest = !is_cmd && (word[3:0] == 4'h0);
  assign run_inc = cmd_run + RUN_W'(1);

  // A note_done level already high on entry must fall once before it counts.
  assign done_edge = armed && note_done;

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    word_d     = word;
    cmd_run_d  = cmd_run;
    mode_d     = mode;
    note_d     = note;
    tone_d     = tone;
    bpm_d      = default_bpm;
    fault_d    = fault;

    case (state)
      S_IDLE: begin
        if (play) begin
          state_d    = S_SETTLE;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      S_SETTLE: begin
        if (wait_cnt == '0) begin
          word_d  = mem_data;
          state_d = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt - CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_end) begin
          state_d = S_END;
        end else if (is_cmd) begin
          bpm_d     = word[7:0];
          cmd_run_d = run_inc;
          if (run_inc >= RUN_LIMIT) begin
            fault_d = 1'b1;
            state_d = S_END;
          end else begin
            state_d = S_ADVANCE;
          end
        end else if (is_rest) begin
          state_d = S_ADVANCE;
        end else begin
          mode_d    = word[15:14];
          tone_d    = word[13:8];
          note_d    = word[3:0];
          cmd_run_d = '0;
          state_d   = play ? S_PLAYING : S_PAUSED;
        end
      end
      S_PLAYING: begin
        if (done_edge) begin
          state_d = S_ADVANCE;
        end else if (!play) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (play) begin
          state_d = S_PLAYING;
        end
      end
      S_ADVANCE: begin
        state_d    = S_SETTLE;
        wait_cnt_d = WAIT_LOAD;
      end
      S_END: begin
        mode_d    = '0;
        note_d    = '0;
        tone_d    = '0;
        cmd_run_d = '0;
        state_d   = S_STOPPED;
      end
      S_STOPPED: begin
        if (!play) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arming restarts on every entry into PLAYING, including resume from pause.
  assign armed_d = (state == S_PLAYING) && (state_d == S_PLAYING) && (armed || !note_done);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      word        <= '0;
      cmd_run     <= '0;
      armed       <= 1'b0;
      mode        <= '0;
      note        <= '0;
      tone        <= '0;
      default_bpm <= BPM_INIT;
      fault       <= 1'b0;
      mem_next    <= 1'b0;
      mem_rewind  <= 1'b0;
      end_song    <= 1'b0;
      note_valid  <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      word        <= word_d;
      cmd_run     <= cmd_run_d;
      armed       <= armed_d;
      mode        <= mode_d;
      note        <= note_d;
      tone        <= tone_d;
      default_bpm <= bpm_d;
      fault       <= fault_d;
      mem_next    <= (state_d == S_ADVANCE);
      mem_rewind  <= (state_d == S_END);
      end_song    <= (state_d == S_END);
      note_valid  <= (state_d == S_PLAYING);
    end
  end

  // ADVANCE and END are single-cycle states, so their strobes never overlap.
  a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(mem_next && mem_rewind));
  a_next_single: assert property (@(posedge clk) disable iff (rst) mem_next |=> !mem_next);

endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
// tb_song_sequencer: drives songs from a modelled memory and checks note,
// tempo, fault and pulse behaviour against a song-level reference model.
module tb_song_sequencer;

  localparam int READ_WAIT   = 4;
  localparam int BPM_RESET   = 80;
  localparam int MAX_CMD_RUN = 8;
  localparam int STEP        = READ_WAIT + 2;
  localparam int EVENT_LIMIT = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic        play;
  logic        note_done;
  logic [15:0] mem_data;
  logic        mem_next, mem_rewind, note_valid, end_song, fault;
  logic [1:0]  mode;
  logic [3:0]  note;
  logic [5:0]  tone;
  logic [7:0]  default_bpm;

  always #5 clk = ~clk;

  song_sequencer #(
    .READ_WAIT  (READ_WAIT),
    .BPM_RESET  (BPM_RESET),
    .MAX_CMD_RUN(MAX_CMD_RUN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .mem_data   (mem_data),
    .note_done  (note_done),
    .mem_next   (mem_next),
    .mem_rewind (mem_rewind),
    .note_valid (note_valid),
    .mode       (mode),
    .note       (note),
    .tone       (tone),
    .default_bpm(default_bpm),
    .end_song   (end_song),
    .fault      (fault)
  );

  // Memory model: after an advance the data bus shows a stale word for a while.
  logic [15:0] mem [0:31];
  int          addr = 0;
  int          lag = 0;
  int          glitch_len = 0;
  logic [15:0] glitch_word = 16'hC0C0;

  always @(posedge clk) begin
    if (rst || mem_rewind) begin
      addr <= 0;
      lag  <= 0;
    end else if (mem_next) begin
      addr <= addr + 1;
      lag  <= glitch_len;
    end else if (lag > 0) begin
      lag <= lag - 1;
    end
  end

  assign mem_data = (lag > 0) ? glitch_word : mem[addr[4:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int mnext_cnt = 0;
  int rew_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_next) mnext_cnt++;
    if (mem_rewind) rew_cnt++;
    if (mem_next || mem_rewind) check("next_rewind_excl", 32'(mem_next & mem_rewind), 32'd0);
    if (end_song || mem_rewind) check("end_rewind_pair", 32'(end_song), 32'(mem_rewind));
  endtask

  // Song-level reference: what each word of the song should cause.
  typedef struct {
    logic [1:0] mode;
    logic [5:0] tone;
    logic [3:0] dur;
    int         skips;
  } exp_note_t;

  exp_note_t  q_notes[$];
  logic [7:0] m_bpm = 8'(BPM_RESET);
  bit         m_fault = 1'b0;
  int         end_skips;
  int         exp_adv;

  function automatic void predict(input int len);
    int run;
    int skips;
    logic [15:0] w;
    exp_note_t e;
    run   = 0;
    skips = 0;
    q_notes.delete();
    end_skips = 0;
    exp_adv   = len - 1;
    for (int i = 0; i < len; i++) begin
      w = mem[i];
      if (w[15:14] == 2'b11) begin
        if (w[7:0] == 8'h00) begin
          end_skips = skips;
          exp_adv   = i;
          return;
        end
        m_bpm = w[7:0];
        run++;
        if (run >= MAX_CMD_RUN) begin
          m_fault   = 1'b1;
          end_skips = skips;
          exp_adv   = i;
          return;
        end
        skips++;
      end else if (w[3:0] == 4'h0) begin
        skips++;
      end else begin
        e.mode  = w[15:14];
        e.tone  = w[13:8];
        e.dur   = w[3:0];
        e.skips = skips;
        q_notes.push_back(e);
        skips = 0;
        run   = 0;
      end
    end
  endfunction

  task automatic wait_event(input int done_width, output int n);
    n = 0;
    while (n < EVENT_LIMIT) begin
      tick();
      n++;
      if (n == done_width) note_done = 1'b0;
      if (note_valid || end_song) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_note_valid"}, 32'(note_valid), 32'd0);
    check({tag, "_mem_next"}, 32'(mem_next), 32'd0);
    check({tag, "_mem_rewind"}, 32'(mem_rewind), 32'd0);
    check({tag, "_end_song"}, 32'(end_song), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_fields"}, 32'({mode, tone, note}), 32'd0);
    check({tag, "_bpm"}, 32'(default_bpm), 32'(BPM_RESET));
  endtask

  // Plays one loaded song; pause < 0 selects random pauses.
  task automatic run_song(input int len, input int pause, input bit allow_stale);
    int n, lat_base, width, p, k, base_next;
    exp_note_t e;
    predict(len);
    base_next = mnext_cnt;
    lat_base  = STEP;
    width     = 0;
    play      = 1'b1;
    while (q_notes.size() > 0) begin
      e = q_notes.pop_front();
      wait_event(width, n);
      check("note_latency", n, lat_base + e.skips * STEP);
      check("note_valid", 32'(note_valid), 32'd1);
      check("note_fields", 32'({mode, tone, note}), 32'({e.mode, e.tone, e.dur}));
      if (allow_stale && $urandom_range(0, 3) == 0) begin
        note_done = 1'b1;
        repeat (3) tick();
        check("stale_done_ignored", 32'(note_valid), 32'd1);
        note_done = 1'b0;
      end
      p = (pause >= 0) ? pause : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 50)) : 0);
      if (p > 0) begin
        k    = mnext_cnt;
        play = 1'b0;
        tick();
        check("pause_note_valid", 32'(note_valid), 32'd0);
        repeat (p - 1) tick();
        check("pause_fields", 32'({mode, tone, note}), 32'({e.mode, e.tone, e.dur}));
        check("pause_still_low", 32'(note_valid), 32'd0);
        play = 1'b1;
        tick();
        check("resume_note_valid", 32'(note_valid), 32'd1);
        check("resume_fields", 32'({mode, tone, note}), 32'({e.mode, e.tone, e.dur}));
        check("pause_no_next", mnext_cnt, k);
      end
      k = mnext_cnt;
      repeat ($urandom_range(1, 5)) tick();
      check("hold_valid", 32'(note_valid), 32'd1);
      check("hold_no_next", mnext_cnt, k);
      note_done = 1'b1;
      width     = $urandom_range(1, 3);
      lat_base  = STEP + 1;
    end
    wait_event(width, n);
    check("end_latency", n, lat_base + end_skips * STEP);
    check("end_song", 32'(end_song), 32'd1);
    check("end_rewind", 32'(mem_rewind), 32'd1);
    check("end_fault", 32'(fault), 32'(m_fault));
    check("end_bpm", 32'(default_bpm), 32'(m_bpm));
    check("end_note_valid", 32'(note_valid), 32'd0);
    check("advance_count", mnext_cnt - base_next, exp_adv);
    tick();
    check("end_pulse_width", 32'({end_song, mem_rewind}), 32'd0);
    check("end_fields_clear", 32'({mode, tone, note}), 32'd0);
    k = mnext_cnt;
    repeat (8) tick();
    check("stopped_no_next", mnext_cnt, k);
    check("stopped_no_note", 32'(note_valid), 32'd0);
    play = 1'b0;
    repeat (2) tick();
  endtask

  task automatic reset_mid(input bit in_playing);
    int n, k;
    mem[0] = 16'h1A03;
    mem[1] = 16'hC000;
    k      = rew_cnt;
    play   = 1'b1;
    if (in_playing) begin
      wait_event(0, n);
      check("rst_pre_playing", 32'(note_valid), 32'd1);
    end else begin
      repeat (2) tick();
    end
    rst = 1'b1;
    tick();
    check_reset_outputs(in_playing ? "rst_playing" : "rst_settle");
    play = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_rewind", rew_cnt, k);
    m_bpm   = 8'(BPM_RESET);
    m_fault = 1'b0;
  endtask

  task automatic random_song();
    int len, kind;
    len = $urandom_range(2, 10);
    for (int i = 0; i < len - 1; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)
        mem[i] = {2'($urandom_range(0, 2)), 6'($urandom), 4'($urandom), 4'($urandom_range(1, 15))};
      else if (kind == 6)
        mem[i] = {2'($urandom_range(0, 2)), 6'($urandom), 4'($urandom), 4'h0};
      else
        mem[i] = {2'b11, 6'($urandom), 8'($urandom_range(1, 255))};
    end
    mem[len - 1] = {2'b11, 6'($urandom), 8'h00};
    glitch_word  = 16'($urandom);
    glitch_len   = $urandom_range(0, 3);
    run_song(len, -1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    play      = 1'b0;
    note_done = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    repeat (3) tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    // Tempo command, one note, end of song.
    mem[0] = 16'hC064; mem[1] = 16'h1A03; mem[2] = 16'hC000;
    glitch_word = 16'hC0C0; glitch_len = 2;
    run_song(3, 0, 1'b0);

    // Stale 0xC0C0 on the bus right after the advance must not be sampled.
    mem[0] = 16'h0501; mem[1] = 16'hC064; mem[2] = 16'hC000;
    run_song(3, 0, 1'b0);

    // Long pause in the middle of a note.
    mem[0] = 16'h8505; mem[1] = 16'hC000;
    run_song(2, 50, 1'b0);

    // Zero-duration rest is skipped, the next note plays.
    mem[0] = 16'h4200; mem[1] = 16'h4203; mem[2] = 16'hC000;
    run_song(3, 0, 1'b0);

    // Runaway command stream trips the fault.
    for (int i = 0; i < 9; i++) mem[i] = 16'hFFFF;
    run_song(9, 0, 1'b0);

    for (int s = 0; s < 6; s++) random_song();

    glitch_len = 0;
    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int s = 0; s < 14; s++) random_song();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
